vector_sequencer: RTL and testbench

Synchronous stimulus-and-capture stage that sits directly upstream of the lab's 4-input/2-output combinational exercise blocks. On a start request it drives the input vector through all 2^N combinations in ascending binary order, holding each for HOLD clock cycles. It samples the block's two outputs (f, g) at the end of each hold window and packs them into a response word, so that the previous hand-stepped bench becomes a single self-checking, cycle-accurate sweep.

---
 rtl/vector_sequencer_pkg.sv | 14 +
 rtl/vector_sequencer_mod_counter.sv | 27 ++
 rtl/vector_sequencer.sv | 94 +++++++++
 tb/tb_vector_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer: FSM state encodings and
// default sweep geometry.
package vector_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEF_N    = 4;
  localparam int DEF_HOLD = 10;

endpackage

// File: rtl/vector_sequencer_mod_counter.sv
// Modulo-MOD counter with synchronous clear and enable; tc flags the final
// count so the caller knows a window is ending.
module mod_counter #(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (MOD > 1) ? $clog2(MOD) : 1;

  logic [W-1:0] count;

  assign tc = (count == W'(MOD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vector_sequencer.sv
// Sweeps an N-input vector through all 2^N codes, holding each HOLD cycles,
// and captures the downstream block's (f, g) pair at the end of every window.
module vector_sequencer
  import vector_sequencer_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int HOLD = DEF_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f,
  input  logic                 g,
  output logic [N-1:0]         vec,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         idx,
  output logic [2*(1<<N)-1:0]  resp
);

  localparam int NV = 1 << N;

  state_t state, state_n;
  logic   tc;
  logic   accept;
  logic   sample;
  logic   last;

  // Hold counter runs only while driving; any other state or an abort parks it at 0.
  mod_counter #(.MOD(HOLD)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != DRIVE) || abort),
    .enable (state == DRIVE),
    .tc     (tc)
  );

  assign last   = (idx == N'(NV - 1));
  assign accept = (state == IDLE) && start && !abort;
  assign sample = (state == DRIVE) && !abort && tc;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = DRIVE;
      DRIVE: begin
        if (abort)              state_n = IDLE;
        else if (tc && last)    state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with vec.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      valid <= (state_n == DRIVE);
      busy  <= (state_n == DRIVE);
      done  <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_n != DRIVE) begin
      idx <= '0;
      vec <= '0;
    end else if (accept) begin
      idx <= '0;
      vec <= '0;
    end else if (sample && !last) begin
      idx <= idx + N'(1);
      vec <= idx + N'(1);
    end
  end

  // resp survives aborts and completion; only a new sweep or reset wipes it.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      resp <= '0;
    end else if (sample) begin
      resp[2*int'(idx) +: 2] <= {f, g};
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: table-driven sweeps plus directed
// sequences for abort, start interactions, HOLD=1 and reset mid-run.
module tb_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, start1;
  logic        f, g, f1, g1;
  logic [3:0]  vec, idx, vec1, idx1;
  logic        valid, busy, done, valid1, busy1, done1;
  logic [31:0] resp, resp1;

  int          fMode;
  logic        fConst, gConst;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       name;
    int          mode;
    logic        fc;
    logic        gc;
    logic [31:0] expResp;
  } sweep_vec_t;

  sweep_vec_t sweeps[3];

  always #5 clk = ~clk;

  assign f  = (fMode == 0) ? (vec[3] & vec[2]) : fConst;
  assign g  = (fMode == 0) ? (vec[1] | vec[0]) : gConst;
  assign f1 = vec1[3] & vec1[2];
  assign g1 = vec1[1] | vec1[0];

  vector_sequencer #(.N(4), .HOLD(10)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f(f), .g(g),
    .vec(vec), .valid(valid), .busy(busy), .done(done), .idx(idx), .resp(resp)
  );

  vector_sequencer #(.N(4), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .f(f1), .g(g1),
    .vec(vec1), .valid(valid1), .busy(busy1), .done(done1), .idx(idx1), .resp(resp1)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Entered at a negedge with start low; returns at the negedge after done.
  task automatic applyStimulus(input string name, input logic [31:0] expResp);
    int cyc = 0;
    int bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && cyc < 400) begin
      if (vec !== 4'(cyc / 10) || idx !== 4'(cyc / 10) || valid !== 1'b1) bad++;
      cyc++;
      @(negedge clk);
    end
    checkOutput({name, "_busy_cycles"}, 64'(cyc), 64'd160);
    checkOutput({name, "_vec_steps"}, 64'(bad), 64'd0);
    checkOutput({name, "_done_pulse"}, {63'd0, done}, 64'd1);
    checkOutput({name, "_done_valid"}, {63'd0, valid}, 64'd0);
    checkOutput({name, "_resp"}, {32'd0, resp}, {32'd0, expResp});
    @(negedge clk);
    checkOutput({name, "_done_drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int cyc;
    int bad;
    sweeps[0] = '{"ref",    0, 1'b0, 1'b0, 32'hFE54_5454};
    sweeps[1] = '{"const01", 1, 1'b0, 1'b1, 32'h5555_5555};
    sweeps[2] = '{"const10", 1, 1'b1, 1'b0, 32'hAAAA_AAAA};

    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    fMode = 0; fConst = 1'b0; gConst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_vec",   {60'd0, vec},   64'd0);
    checkOutput("reset_idx",   {60'd0, idx},   64'd0);
    checkOutput("reset_flags", {61'd0, valid, busy, done}, 64'd0);
    checkOutput("reset_resp",  {32'd0, resp},  64'd0);
    checkOutput("reset_resp1", {32'd0, resp1}, 64'd0);

    // Tests 1 and 3: table-driven full sweeps
    for (int i = 0; i < 3; i++) begin
      fMode  = sweeps[i].mode;
      fConst = sweeps[i].fc;
      gConst = sweeps[i].gc;
      applyStimulus(sweeps[i].name, sweeps[i].expResp);
    end
    fMode = 0;

    // Test 2: abort on the 35th DRIVE cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 35; c++) @(negedge clk);
    checkOutput("abort_idx_frozen", {60'd0, idx}, 64'd3);
    checkOutput("abort_busy_before", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_resp", {32'd0, resp}, 64'h14);
    checkOutput("abort_idx_idle", {60'd0, idx}, 64'd0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 64'(bad), 64'd0);
    checkOutput("abort_resp_kept", {32'd0, resp}, 64'h14);

    // Test 4a: start held high through a sweep
    start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("held_busy_cycles", 64'(cyc), 64'd160);
    checkOutput("held_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    checkOutput("held_gap_idle", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    checkOutput("held_restart", {62'd0, busy, valid}, 64'd3);
    checkOutput("held_restart_vec", {60'd0, vec}, 64'd0);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("held_abort_idle", {63'd0, busy}, 64'd0);

    // Test 4b: start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("start_abort_idle", {61'd0, busy, valid, done}, 64'd0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);

    // Test 5: HOLD=1 instance
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0; bad = 0;
    while (busy1 && cyc < 100) begin
      if (vec1 !== 4'(cyc) || valid1 !== 1'b1) bad++;
      cyc++;
      @(negedge clk);
    end
    checkOutput("hold1_busy_cycles", 64'(cyc), 64'd16);
    checkOutput("hold1_vec_steps", 64'(bad), 64'd0);
    checkOutput("hold1_done", {63'd0, done1}, 64'd1);
    checkOutput("hold1_resp", {32'd0, resp1}, 64'hFE54_5454);

    // Test 6: reset at DRIVE cycle 50, then a normal sweep
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 50; c++) @(negedge clk);
    checkOutput("rst_pre_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_vec_idx", {56'd0, vec, idx}, 64'd0);
    checkOutput("rst_flags", {61'd0, valid, busy, done}, 64'd0);
    checkOutput("rst_resp", {32'd0, resp}, 64'd0);
    checkOutput("rst_resp1", {32'd0, resp1}, 64'd0);
    applyStimulus("after_rst", 32'hFE54_5454);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
